// File: rtl/i2s_codec_master.sv
// i2s_codec_master
// Codec end of an I2S link. Generates mclk, sclk and lrck from clk,
// serialises a stereo pair onto sdi and deserialises sdo into a stereo pair.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   in_l/in_r/in_vld stereo pair to transmit, accepted when in_vld && in_rdy
//   in_rdy           holding register empty
//   out_l/out_r      pair captured from sdo, qualified by 1-cycle out_vld
//   underrun         1-cycle pulse, a frame started with no pending pair
//   mclk/sclk/lrck   registered master clock, bit clock, word select (1=right)
//   sdi              registered serial data toward the FPGA
//   sdo              serial data from the FPGA
module i2s_codec_master #(
  parameter int DATA_W    = 24,
  parameter int SLOT_BITS = 32,
  parameter int MCLK_HALF = 2,
  parameter int SCLK_HALF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_l,
  input  logic [DATA_W-1:0] in_r,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_vld,
  output logic              underrun,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic              sdi,
  input  logic              sdo
);

  localparam int MW = $clog2(MCLK_HALF + 1);
  localparam int SW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [MW-1:0] MCLK_LAST  = MW'(MCLK_HALF - 1);
  localparam logic [MW-1:0] MCLK_ONE   = MW'(1);
  localparam logic [SW-1:0] SCLK_LAST  = SW'(SCLK_HALF - 1);
  localparam logic [SW-1:0] SCLK_ONE   = SW'(1);
  localparam logic [BW-1:0] BIT_ZERO   = BW'(0);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] SLOT_LEN   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] FRAME_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_W);

  logic [MW-1:0]     mclk_cnt_r;
  logic              mclk_r;
  logic [SW-1:0]     sclk_cnt_r;
  logic              sclk_r;
  logic [BW-1:0]     bit_cnt_r;
  logic              lrck_r;
  logic              sdi_r;
  logic [DATA_W-1:0] hold_l_r, hold_r_r;
  logic              in_rdy_r;
  logic [DATA_W-1:0] act_l_r, act_r_r;
  logic [DATA_W-1:0] cap_l_r, cap_r_r;
  logic [DATA_W-1:0] out_l_r, out_r_r;
  logic              out_vld_r;
  logic              underrun_r;

  logic              sclk_tick_s, rise_s, fall_s, wrap_s, boundary_s;
  logic [BW-1:0]     bit_nxt_s, cur_pos_s, nxt_pos_s;
  logic              cur_data_s, accept_s, sdi_nxt_s;
  logic [DATA_W-1:0] nxt_word_s, nxt_shift_s;

  // Bit-clock events, slot positions and the next serial output bit
  always_comb begin
    sclk_tick_s = (sclk_cnt_r == SCLK_LAST);
    rise_s      = sclk_tick_s && !sclk_r;
    fall_s      = sclk_tick_s && sclk_r;
    wrap_s      = (bit_cnt_r == FRAME_LAST);
    boundary_s  = fall_s && wrap_s;
    bit_nxt_s   = wrap_s ? BIT_ZERO : bit_cnt_r + BIT_ONE;
    cur_pos_s   = (bit_cnt_r >= SLOT_LEN) ? bit_cnt_r - SLOT_LEN : bit_cnt_r;
    nxt_pos_s   = (bit_nxt_s >= SLOT_LEN) ? bit_nxt_s - SLOT_LEN : bit_nxt_s;
    cur_data_s  = (cur_pos_s >= BIT_ONE) && (cur_pos_s <= DATA_LAST);
    nxt_word_s  = (bit_nxt_s >= SLOT_LEN) ? act_r_r : act_l_r;
    // MSB lands at position 1: shift the wanted bit down to bit 0
    nxt_shift_s = nxt_word_s >> (DATA_LAST - nxt_pos_s);
    if ((nxt_pos_s >= BIT_ONE) && (nxt_pos_s <= DATA_LAST)) begin
      sdi_nxt_s = nxt_shift_s[0];
    end else begin
      sdi_nxt_s = 1'b0;
    end
    accept_s = in_vld && in_rdy_r;
  end

  // Free-running master clock divider
  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt_r <= {MW{1'b0}};
      mclk_r     <= 1'b0;
    end else if (mclk_cnt_r == MCLK_LAST) begin
      mclk_cnt_r <= {MW{1'b0}};
      mclk_r     <= ~mclk_r;
    end else begin
      mclk_cnt_r <= mclk_cnt_r + MCLK_ONE;
    end
  end

  // Bit clock divider; first edge after reset is a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_cnt_r <= {SW{1'b0}};
      sclk_r     <= 1'b0;
    end else if (sclk_tick_s) begin
      sclk_cnt_r <= {SW{1'b0}};
      sclk_r     <= ~sclk_r;
    end else begin
      sclk_cnt_r <= sclk_cnt_r + SCLK_ONE;
    end
  end

  // Frame bit counter, word select and serial output, all moving on sclk falls
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= BIT_ZERO;
      lrck_r    <= 1'b0;
      sdi_r     <= 1'b0;
    end else if (fall_s) begin
      bit_cnt_r <= bit_nxt_s;
      lrck_r    <= (bit_nxt_s >= SLOT_LEN);
      sdi_r     <= sdi_nxt_s;
    end
  end

  // Deserialise sdo on sclk rises into the channel selected by lrck
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_l_r <= {DATA_W{1'b0}};
      cap_r_r <= {DATA_W{1'b0}};
    end else if (rise_s && cur_data_s) begin
      if (lrck_r) begin
        cap_r_r <= {cap_r_r[DATA_W-2:0], sdo};
      end else begin
        cap_l_r <= {cap_l_r[DATA_W-2:0], sdo};
      end
    end
  end

  // Input handshake, frame-boundary reload of the active pair and output publication
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l_r   <= {DATA_W{1'b0}};
      hold_r_r   <= {DATA_W{1'b0}};
      in_rdy_r   <= 1'b1;
      act_l_r    <= {DATA_W{1'b0}};
      act_r_r    <= {DATA_W{1'b0}};
      out_l_r    <= {DATA_W{1'b0}};
      out_r_r    <= {DATA_W{1'b0}};
      out_vld_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      out_vld_r  <= boundary_s;
      // in_rdy high means the holding register is empty
      underrun_r <= boundary_s && in_rdy_r;
      if (boundary_s) begin
        out_l_r <= cap_l_r;
        out_r_r <= cap_r_r;
      end
      if (boundary_s && !in_rdy_r) begin
        act_l_r  <= hold_l_r;
        act_r_r  <= hold_r_r;
        in_rdy_r <= 1'b1;
      end else begin
        if (boundary_s) begin
          act_l_r <= {DATA_W{1'b0}};
          act_r_r <= {DATA_W{1'b0}};
        end
        // A pair accepted on an empty boundary waits in hold for the next frame
        if (accept_s) begin
          hold_l_r <= in_l;
          hold_r_r <= in_r;
          in_rdy_r <= 1'b0;
        end
      end
    end
  end

  assign in_rdy   = in_rdy_r;
  assign out_l    = out_l_r;
  assign out_r    = out_r_r;
  assign out_vld  = out_vld_r;
  assign underrun = underrun_r;
  assign mclk     = mclk_r;
  assign sclk     = sclk_r;
  assign lrck     = lrck_r;
  assign sdi      = sdi_r;

endmodule
